// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit.
// Opcode patterns are value/mask pairs so decoders can share one matcher.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
    C_CBZ, C_B, C_LDUR, C_STUR, C_MOVZ
  } class_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SIGN_I   = 2'b00;
  localparam logic [1:0] SIGN_D   = 2'b01;
  localparam logic [1:0] SIGN_B   = 2'b10;
  localparam logic [1:0] SIGN_CBZ = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [10:0] value;
    logic [10:0] mask;
  } op_pat_t;

  localparam op_pat_t PAT_AND  = '{11'b10001010000, 11'b11111111111};
  localparam op_pat_t PAT_ORR  = '{11'b10101010000, 11'b11111111111};
  localparam op_pat_t PAT_ADD  = '{11'b10001011000, 11'b11111111111};
  localparam op_pat_t PAT_SUB  = '{11'b11001011000, 11'b11111111111};
  localparam op_pat_t PAT_ADDI = '{11'b10010001000, 11'b11111111110};
  localparam op_pat_t PAT_SUBI = '{11'b11010001000, 11'b11111111110};
  localparam op_pat_t PAT_CBZ  = '{11'b10110100000, 11'b11111111000};
  localparam op_pat_t PAT_B    = '{11'b00010100000, 11'b11111100000};
  localparam op_pat_t PAT_LDUR = '{11'b11111000010, 11'b11111111111};
  localparam op_pat_t PAT_STUR = '{11'b11111000000, 11'b11111111111};
  localparam op_pat_t PAT_MOVZ = '{11'b11010010100, 11'b11111111100};

  function automatic logic op_match(input logic [10:0] op, input op_pat_t p);
    return (op & p.mask) == p.value;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake between the control unit (master) and instruction/data memory.
// mem_req rises and is held with mem_sel/mem_we stable until a rising edge samples mem_ready high; that edge completes the access.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/opcode_classify.sv
// Combinational LEGv8 opcode classifier; also intended for reuse by the pipelined core.
module opcode_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output class_e      cls,
  output logic        illegal
);

  always_comb begin
    cls = C_NONE;
    if      (op_match(opcode, PAT_AND))  cls = C_AND;
    else if (op_match(opcode, PAT_ORR))  cls = C_ORR;
    else if (op_match(opcode, PAT_ADD))  cls = C_ADD;
    else if (op_match(opcode, PAT_SUB))  cls = C_SUB;
    else if (op_match(opcode, PAT_ADDI)) cls = C_ADDI;
    else if (op_match(opcode, PAT_SUBI)) cls = C_SUBI;
    else if (op_match(opcode, PAT_CBZ))  cls = C_CBZ;
    else if (op_match(opcode, PAT_B))    cls = C_B;
    else if (op_match(opcode, PAT_LDUR)) cls = C_LDUR;
    else if (op_match(opcode, PAT_STUR)) cls = C_STUR;
    else if (op_match(opcode, PAT_MOVZ)) cls = C_MOVZ;
    illegal = (cls == C_NONE);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/exec/mem/wb sequencing with
// memory wait timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  multicycle_control_if.master mem,
  output logic                ir_write,
  output logic                pc_inc,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic                branch,
  output logic                uncond_branch,
  output logic                movz,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [1:0]          signop,
  output logic [1:0]          shamt,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired,
  output logic [2:0]          state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e             state, state_nxt;
  class_e             cls_dec, cls_q;
  logic               illegal;
  logic [1:0]         hw_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   retired_q;
  logic [3:0]         alu_sel;
  logic               timeout;
  logic               retire_evt;

  opcode_classify u_classify (
    .opcode  (opcode[10:0]),
    .cls     (cls_dec),
    .illegal (illegal)
  );

  // Success wins when ready arrives in the same cycle the counter saturates.
  assign timeout    = (wait_cnt == WAIT_W'(MAX_WAIT)) && !mem.mem_ready;
  assign retire_evt = (state_nxt == S_FETCH) &&
                      (state == S_EXEC || state == S_MEM || state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_nxt = S_DECODE;
                else if (timeout)  state_nxt = S_TRAP;
      S_DECODE: state_nxt = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cls_q == C_CBZ || cls_q == C_B)         state_nxt = S_FETCH;
        else if (cls_q == C_LDUR || cls_q == C_STUR) state_nxt = S_MEM;
        else                                         state_nxt = S_WB;
      end
      S_MEM:    if (mem.mem_ready) state_nxt = (cls_q == C_LDUR) ? S_WB : S_FETCH;
                else if (timeout)  state_nxt = S_TRAP;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q     <= C_NONE;
      hw_q      <= 2'b00;
      wait_cnt  <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      if (state == S_DECODE) begin
        cls_q <= cls_dec;
        hw_q  <= opcode[1:0];
      end
      // Any state change clears the counter, so FETCH/MEM always start from zero.
      if (state_nxt != state)                                           wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !mem.mem_ready)  wait_cnt <= wait_cnt + 1'b1;
      if (state != S_TRAP && state_nxt == S_TRAP)
        cause_q <= (state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (retire_evt) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_sel   = 1'b0;
    mem.mem_we    = 1'b0;
    ir_write      = 1'b0;
    pc_inc        = 1'b0;
    reg2loc       = 1'b0;
    alusrc        = 1'b0;
    mem2reg       = 1'b0;
    regwrite      = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    movz          = 1'b0;
    alu_sel       = ALU_AND;
    signop        = SIGN_I;
    shamt         = 2'b00;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      case (cls_q)
        C_AND:  alu_sel = ALU_AND;
        C_ORR:  alu_sel = ALU_ORR;
        C_ADD:  alu_sel = ALU_ADD;
        C_SUB:  alu_sel = ALU_SUB;
        C_ADDI: begin alu_sel = ALU_ADD;   alusrc = 1'b1; end
        C_SUBI: begin alu_sel = ALU_SUB;   alusrc = 1'b1; end
        C_CBZ:  begin alu_sel = ALU_PASSB; signop = SIGN_CBZ; reg2loc = 1'b1; end
        C_B:    signop = SIGN_B;
        C_LDUR: begin alu_sel = ALU_ADD;   alusrc = 1'b1; signop = SIGN_D; end
        C_STUR: begin alu_sel = ALU_ADD;   alusrc = 1'b1; signop = SIGN_D; reg2loc = 1'b1; end
        C_MOVZ: begin alu_sel = ALU_PASSB; alusrc = 1'b1; movz = 1'b1; shamt = hw_q; end
        default: ;
      endcase
    end
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
        pc_inc      = mem.mem_ready;
      end
      S_EXEC: begin
        branch        = (cls_q == C_CBZ);
        uncond_branch = (cls_q == C_B);
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_sel = 1'b1;
        mem.mem_we  = (cls_q == C_STUR);
        memread     = (cls_q == C_LDUR);
        memwrite    = (cls_q == C_STUR);
      end
      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls_q == C_LDUR);
      end
      default: ;
    endcase
  end

  assign aluop      = ALUOP_W'(alu_sel);
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle-by-cycle expectations built
// from instruction kind, fetch/memory wait counts and the per-kind control table.
module tb_multicycle_control;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;

  localparam int K_AND = 0, K_ORR = 1, K_ADD = 2, K_SUB = 3, K_ADDI = 4, K_SUBI = 5,
                 K_CBZ = 6, K_B = 7, K_LDUR = 8, K_STUR = 9, K_MOVZ = 10, K_ILL = 11;

  typedef struct packed {
    logic mem_req, mem_sel, mem_we, ir_write, pc_inc;
    logic reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch, uncond, movz;
    logic [3:0] aluop;
    logic [1:0] signop;
    logic [1:0] shamt;
    logic       trap;
    logic [1:0] cause;
  } ctl_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] signop;
    logic       reg2loc;
    logic       movz;
  } dp_t;

  typedef struct packed {
    logic [2:0]       st;
    logic             rdy;
    logic [10:0]      op;
    ctl_t             ctl;
    logic [CNT_W-1:0] ret;
  } cyc_t;

  logic clk, rst;
  logic [10:0] opcode;
  logic ir_write, pc_inc, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
  logic branch, uncond_branch, movz, trap;
  logic [3:0] aluop;
  logic [1:0] signop, shamt, trap_cause;
  logic [CNT_W-1:0] retired;
  logic [2:0] state_o;
  ctl_t obs;

  multicycle_control_if mem_bus ();

  multicycle_control #(.OPCODE_W(11), .ALUOP_W(4), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem(mem_bus),
    .ir_write(ir_write), .pc_inc(pc_inc), .reg2loc(reg2loc), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .branch(branch), .uncond_branch(uncond_branch), .movz(movz), .aluop(aluop),
    .signop(signop), .shamt(shamt), .trap(trap), .trap_cause(trap_cause),
    .retired(retired), .state_o(state_o)
  );

  assign obs = {mem_bus.mem_req, mem_bus.mem_sel, mem_bus.mem_we, ir_write, pc_inc,
                reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch,
                uncond_branch, movz, aluop, signop, shamt, trap, trap_cause};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [$bits(cyc_t)-1:0] exp_q[$];
  logic [CNT_W-1:0] ret_m;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // reference model
  function automatic logic [10:0] gen_op(input int k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_AND:  return 11'b10001010000;
      K_ORR:  return 11'b10101010000;
      K_ADD:  return 11'b10001011000;
      K_SUB:  return 11'b11001011000;
      K_ADDI: return {10'b1001000100, r[0]};
      K_SUBI: return {10'b1101000100, r[0]};
      K_CBZ:  return {8'b10110100, r[2:0]};
      K_B:    return {6'b000101, r[4:0]};
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_MOVZ: return {9'b110100101, r[1:0]};
      default: case (r[1:0])
        2'd0:    return 11'b00000000000;
        2'd1:    return 11'b11111111111;
        2'd2:    return 11'b10001011001;
        default: return 11'b01010101010;
      endcase
    endcase
  endfunction

  function automatic dp_t dp_of(input int k);
    case (k)
      K_AND:  return '{4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
      K_ORR:  return '{4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};
      K_ADD:  return '{4'b0010, 1'b0, 2'b00, 1'b0, 1'b0};
      K_SUB:  return '{4'b0110, 1'b0, 2'b00, 1'b0, 1'b0};
      K_ADDI: return '{4'b0010, 1'b1, 2'b00, 1'b0, 1'b0};
      K_SUBI: return '{4'b0110, 1'b1, 2'b00, 1'b0, 1'b0};
      K_CBZ:  return '{4'b0111, 1'b0, 2'b11, 1'b1, 1'b0};
      K_B:    return '{4'b0000, 1'b0, 2'b10, 1'b0, 1'b0};
      K_LDUR: return '{4'b0010, 1'b1, 2'b01, 1'b0, 1'b0};
      K_STUR: return '{4'b0010, 1'b1, 2'b01, 1'b1, 1'b0};
      K_MOVZ: return '{4'b0111, 1'b1, 2'b00, 1'b0, 1'b1};
      default: return '0;
    endcase
  endfunction

  function automatic ctl_t with_dp(input dp_t d, input logic [1:0] sh);
    ctl_t c;
    c = '0;
    c.aluop = d.aluop; c.alusrc = d.alusrc; c.signop = d.signop;
    c.reg2loc = d.reg2loc; c.movz = d.movz; c.shamt = sh;
    return c;
  endfunction

  task automatic push(input logic [2:0] st, input logic rdy, input logic [10:0] op, input ctl_t c);
    cyc_t r;
    r.st = st; r.rdy = rdy; r.op = op; r.ctl = c; r.ret = ret_m;
    exp_q.push_back(r);
  endtask

  task automatic add_trap(input logic [1:0] cause, input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0; c.trap = 1'b1; c.cause = cause;
      push(ST_TRAP, 1'($urandom), 11'($urandom), c);
    end
  endtask

  // fw/mw: cycles mem_ready stays low before it rises; beyond MAX_WAIT means it never does.
  task automatic add_instr(input int k, input logic [10:0] op, input int fw, input int mw);
    ctl_t c;
    dp_t d;
    logic [1:0] sh;
    int lim;
    d  = dp_of(k);
    sh = (k == K_MOVZ) ? op[1:0] : 2'b00;
    lim = (fw > MAX_WAIT) ? MAX_WAIT : fw;
    for (int i = 0; i <= lim; i++) begin
      c = '0; c.mem_req = 1'b1;
      if (i == fw) begin c.ir_write = 1'b1; c.pc_inc = 1'b1; end
      push(ST_FETCH, i == fw, 11'($urandom), c);
    end
    if (fw > MAX_WAIT) begin add_trap(2'b10, 4); return; end
    push(ST_DECODE, 1'($urandom), op, '0);
    if (k == K_ILL) begin add_trap(2'b01, 4); return; end
    c = with_dp(d, sh);
    c.branch = (k == K_CBZ);
    c.uncond = (k == K_B);
    push(ST_EXEC, 1'($urandom), op, c);
    if (k == K_CBZ || k == K_B) begin ret_m = ret_m + 1'b1; return; end
    if (k == K_LDUR || k == K_STUR) begin
      lim = (mw > MAX_WAIT) ? MAX_WAIT : mw;
      for (int i = 0; i <= lim; i++) begin
        c = with_dp(d, sh);
        c.mem_req = 1'b1; c.mem_sel = 1'b1;
        c.mem_we = (k == K_STUR); c.memwrite = (k == K_STUR); c.memread = (k == K_LDUR);
        push(ST_MEM, i == mw, op, c);
      end
      if (mw > MAX_WAIT) begin add_trap(2'b10, 4); return; end
      if (k == K_STUR) begin ret_m = ret_m + 1'b1; return; end
    end
    c = with_dp(d, sh);
    c.regwrite = 1'b1;
    c.mem2reg  = (k == K_LDUR);
    push(ST_WB, 1'($urandom), op, c);
    ret_m = ret_m + 1'b1;
  endtask

  // driver tasks
  task automatic run_queue(input int n);
    cyc_t r;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      r = exp_q.pop_front();
      mem_bus.mem_ready = r.rdy;
      opcode = r.op;
      @(negedge clk);
      check_val("state", 64'(state_o), 64'(r.st));
      check_val("ctl", 64'(obs), 64'(r.ctl));
      check_val("retired", 64'(retired), 64'(r.ret));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_state", 64'(state_o), 64'(ST_IDLE));
    check_val("rst_ctl", 64'(obs), 64'd0);
    check_val("rst_retired", 64'(retired), 64'd0);
    exp_q.delete();
    ret_m = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(ST_IDLE, 1'($urandom), 11'($urandom), '0);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    opcode = '0;
    mem_bus.mem_ready = 1'b0;
    ret_m = '0;
    #2;
    do_reset();

    add_instr(K_ADD, 11'b10001011000, 0, 0);
    add_instr(K_LDUR, 11'b11111000010, 0, 3);
    add_instr(K_CBZ, gen_op(K_CBZ), 0, 0);
    add_instr(K_B, gen_op(K_B), 0, 0);
    add_instr(K_MOVZ, 11'b11010010110, 0, 0);
    add_instr(K_STUR, 11'b11111000000, 2, 1);
    add_instr(K_ADDI, gen_op(K_ADDI), MAX_WAIT, 0);
    add_instr(K_STUR, 11'b11111000000, 0, MAX_WAIT);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 10);
      add_instr(k, gen_op(k), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_queue(100000);

    // fetch timeout: ready never rises
    do_reset();
    add_instr(K_ADD, gen_op(K_ADD), MAX_WAIT + 1, 0);
    add_trap(2'b10, 16);
    run_queue(100000);

    // illegal opcode, then recovery by reset
    do_reset();
    add_instr(K_ILL, 11'b00000000000, 1, 0);
    add_trap(2'b01, 20);
    run_queue(100000);
    do_reset();
    add_instr(K_ILL, gen_op(K_ILL), 0, 0);
    run_queue(100000);

    // data-memory timeout
    do_reset();
    add_instr(K_LDUR, 11'b11111000010, 0, MAX_WAIT + 1);
    run_queue(100000);

    // reset in the middle of a STUR memory access
    do_reset();
    add_instr(K_STUR, 11'b11111000000, 0, 5);
    run_queue(4);
    mem_bus.mem_ready = 1'b0;
    #1;
    check_val("mid_mem_req", 64'(mem_bus.mem_req), 64'd1);
    check_val("mid_memwrite", 64'(memwrite), 64'd1);
    do_reset();
    add_instr(K_MOVZ, 11'b11010010110, 0, 0);
    run_queue(100000);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
